// File: rtl/frame_sequencer.sv
// frame_sequencer: frame-level controller for the pixel sensor datapath.
// Steps each frame through ERASE -> EXPOSE -> ADC_RST -> CONVERT -> READ -> DONE
// and drives the pixel array, exposure counter, ADC and readout strobes.
// Optional feature macro: ADC_WATCHDOG_EN (CONVERT timeout and sticky adc_timeout).
module frame_sequencer #(
    parameter int ROWS         = 2,
    parameter int ERASE_CYCLES = 2,
    parameter int READ_CYCLES  = 1,
    parameter int ADC_TIMEOUT  = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  continuous,
    input  logic [5:0]                            expose_cycles,
    input  logic                                  expose_finished,
    input  logic                                  adc_finished,
    output logic                                  frame_reset,
    output logic                                  expose_enable,
    output logic                                  adc_reset,
    output logic                                  convert,
    output logic                                  read,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] read_row,
    output logic                                  frame_done,
    output logic                                  busy,
    output logic                                  adc_timeout,
    output logic [7:0]                            frame_count
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CMAX_ER = (ERASE_CYCLES > READ_CYCLES) ? ERASE_CYCLES : READ_CYCLES;
`ifdef ADC_WATCHDOG_EN
    localparam int CMAX = (CMAX_ER > ADC_TIMEOUT) ? CMAX_ER : ADC_TIMEOUT;
`else
    localparam int CMAX = CMAX_ER;
`endif
    localparam int CW = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_ADC_RST = 3'd3;
    localparam logic [2:0] S_CONVERT = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] row, row_nxt;

    // Next-state logic; the shared counter defaults to 0 so every state entry clears it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        row_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ERASE;
            end
            S_ERASE: begin
                if (cnt == CW'(ERASE_CYCLES - 1))
                    state_nxt = (expose_cycles == 6'd0) ? S_ADC_RST : S_EXPOSE;
                else
                    cnt_nxt = cnt + CW'(1);
            end
            S_EXPOSE: begin
                if (expose_finished) state_nxt = S_ADC_RST;
            end
            S_ADC_RST: begin
                state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                // adc_finished is checked first so a finish on the expiry cycle still succeeds.
                if (adc_finished)
                    state_nxt = S_READ;
`ifdef ADC_WATCHDOG_EN
                else if (cnt == CW'(ADC_TIMEOUT - 1))
                    state_nxt = S_IDLE;
                else
                    cnt_nxt = cnt + CW'(1);
`endif
            end
            S_READ: begin
                row_nxt = row;
                if (cnt == CW'(READ_CYCLES - 1)) begin
                    if (row == RW'(ROWS - 1))
                        state_nxt = S_DONE;
                    else
                        row_nxt = row + RW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                state_nxt = (continuous || start) ? S_ERASE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counter and row registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_reset   <= 1'b0;
            expose_enable <= 1'b0;
            adc_reset     <= 1'b0;
            convert       <= 1'b0;
            read          <= 1'b0;
            read_row      <= '0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_reset   <= (state_nxt == S_ERASE);
            expose_enable <= (state_nxt == S_EXPOSE);
            adc_reset     <= (state_nxt == S_ADC_RST);
            convert       <= (state_nxt == S_CONVERT);
            read          <= (state_nxt == S_READ);
            read_row      <= (state_nxt == S_READ) ? row_nxt : '0;
            frame_done    <= (state_nxt == S_DONE);
            busy          <= (state_nxt != S_IDLE);
            if (state_nxt == S_DONE)
                frame_count <= frame_count + 8'd1;
        end
    end

`ifdef ADC_WATCHDOG_EN
    // Sticky watchdog flag: set on a CONVERT abort, cleared by the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            adc_timeout <= 1'b0;
        else if (state == S_CONVERT && state_nxt == S_IDLE)
            adc_timeout <= 1'b1;
        else if (state == S_IDLE && start)
            adc_timeout <= 1'b0;
    end
`else
    assign adc_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed self-checking bench for frame_sequencer.
// A second instance with ADC_TIMEOUT=8 exercises the watchdog (ADC_WATCHDOG_EN).
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, continuous, expose_finished, adc_finished;
    logic [5:0] expose_cycles;
    logic       frame_reset, expose_enable, adc_reset, convert, read;
    logic [0:0] read_row;
    logic       frame_done, busy, adc_timeout;
    logic [7:0] frame_count;

    logic       w_start;
    logic       w_frame_reset, w_expose_enable, w_adc_reset, w_convert, w_read;
    logic [0:0] w_read_row;
    logic       w_frame_done, w_busy, w_adc_timeout;
    logic [7:0] w_frame_count;

    int tests = 0;
    int fails = 0;
    int n_fr, n_ex, n_ar, n_cv, n_rd, n_done, n_gap, budget;
    logic [7:0] rows_seen;
    logic [7:0] count_before;
    int wcv, wdone;

    always #5 clk = ~clk;

    frame_sequencer #(.ROWS(2), .ERASE_CYCLES(2), .READ_CYCLES(1), .ADC_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .expose_cycles(expose_cycles), .expose_finished(expose_finished),
        .adc_finished(adc_finished), .frame_reset(frame_reset),
        .expose_enable(expose_enable), .adc_reset(adc_reset), .convert(convert),
        .read(read), .read_row(read_row), .frame_done(frame_done), .busy(busy),
        .adc_timeout(adc_timeout), .frame_count(frame_count)
    );

    frame_sequencer #(.ROWS(2), .ERASE_CYCLES(2), .READ_CYCLES(1), .ADC_TIMEOUT(8)) dut_wd (
        .clk(clk), .reset(reset), .start(w_start), .continuous(1'b0),
        .expose_cycles(6'd0), .expose_finished(1'b0),
        .adc_finished(1'b0), .frame_reset(w_frame_reset),
        .expose_enable(w_expose_enable), .adc_reset(w_adc_reset), .convert(w_convert),
        .read(w_read), .read_row(w_read_row), .frame_done(w_frame_done), .busy(w_busy),
        .adc_timeout(w_adc_timeout), .frame_count(w_frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 ns after the edge, and check strobe exclusion on both instances.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("strobe_excl", 32'($countones({frame_reset, expose_enable, adc_reset, convert, read}) <= 1), 1);
        chk("w_strobe_excl", 32'($countones({w_frame_reset, w_expose_enable, w_adc_reset, w_convert, w_read}) <= 1), 1);
    endtask

    // Pulse start, then answer the handshakes and count strobe cycles until the DUT goes idle.
    task automatic run_frames(input int exp_len, input int adc_len, input int stop_frames, input bit inject);
        int ex_run, cv_run;
        bit prev_done;
        n_fr = 0; n_ex = 0; n_ar = 0; n_cv = 0; n_rd = 0; n_done = 0; n_gap = 0;
        rows_seen = '0; ex_run = 0; cv_run = 0; prev_done = 0; budget = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_latency", busy, 1);
        while (busy && budget < 5000) begin
            if (frame_reset) n_fr++;
            if (expose_enable) begin n_ex++; ex_run++; end else ex_run = 0;
            if (adc_reset) n_ar++;
            if (convert) begin n_cv++; cv_run++; end else cv_run = 0;
            if (read) begin n_rd++; rows_seen = {rows_seen[6:0], read_row[0]}; end
            if (prev_done && !frame_reset) n_gap++;
            prev_done = frame_done;
            if (frame_done) n_done++;
            if (convert && n_done == stop_frames - 1) continuous = 1'b0;
            expose_finished = expose_enable && (ex_run == exp_len);
            adc_finished    = (convert && (cv_run == adc_len)) || (inject && expose_enable);
            start           = inject && read && (read_row == 1'b0);
            tick();
            budget++;
        end
        start = 1'b0; expose_finished = 1'b0; adc_finished = 1'b0;
        chk("frame_bound", 32'(budget < 5000), 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; continuous = 1'b0; expose_cycles = 6'd5;
        expose_finished = 1'b0; adc_finished = 1'b0; w_start = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {frame_reset, expose_enable, adc_reset, convert, read, frame_done}, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_timeout", adc_timeout, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single frame with default timing.
        run_frames(5, 10, 1, 0);
        chk("sf_frame_reset", n_fr, 2);
        chk("sf_expose", n_ex, 5);
        chk("sf_adc_reset", n_ar, 1);
        chk("sf_convert", n_cv, 10);
        chk("sf_read", n_rd, 2);
        chk("sf_rows", rows_seen, 8'b01);
        chk("sf_done", n_done, 1);
        chk("sf_count", frame_count, 1);
        chk("sf_idle", busy, 0);
        chk("sf_row_idle", read_row, 0);

        // Zero exposure skips EXPOSE.
        expose_cycles = 6'd0;
        run_frames(5, 10, 1, 0);
        chk("ze_expose", n_ex, 0);
        chk("ze_frame_reset", n_fr, 2);
        chk("ze_adc_reset", n_ar, 1);
        chk("ze_done", n_done, 1);
        chk("ze_count", frame_count, 2);

        // Stray start in READ and adc_finished in EXPOSE are ignored.
        expose_cycles = 6'd5;
        run_frames(5, 10, 1, 1);
        chk("ig_expose", n_ex, 5);
        chk("ig_convert", n_cv, 10);
        chk("ig_read", n_rd, 2);
        chk("ig_done", n_done, 1);
        chk("ig_count", frame_count, 3);
        chk("ig_idle", busy, 0);

        // Continuous: three chained frames, continuous dropped during the third CONVERT.
        count_before = frame_count;
        continuous = 1'b1;
        run_frames(5, 10, 3, 0);
        chk("ct_done", n_done, 3);
        chk("ct_gap", n_gap, 0);
        chk("ct_frame_reset", n_fr, 6);
        chk("ct_rows", rows_seen, 8'b0001_0101);
        chk("ct_count", frame_count, count_before + 8'd3);
        chk("ct_idle", busy, 0);

        // Watchdog instance: adc_finished never arrives.
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        wcv = 0; wdone = 0;
        for (int i = 0; i < 60 && w_busy; i++) begin
            if (w_convert) wcv++;
            if (w_frame_done) wdone++;
            tick();
        end
`ifdef ADC_WATCHDOG_EN
        chk("wd_convert_len", wcv, 8);
        chk("wd_flag", w_adc_timeout, 1);
        chk("wd_idle", w_busy, 0);
        chk("wd_no_done", wdone, 0);
        chk("wd_count", w_frame_count, 0);
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        chk("wd_flag_clear", w_adc_timeout, 0);
        chk("wd_restart", w_frame_reset, 1);
`else
        chk("nowd_stuck", w_convert, 1);
        chk("nowd_busy", w_busy, 1);
        chk("nowd_flag", w_adc_timeout, 0);
`endif

        // Reset during EXPOSE clears everything without waiting for a clock edge.
        expose_cycles = 6'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !expose_enable; i++) tick();
        chk("mr_in_expose", expose_enable, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_expose", expose_enable, 0);
        chk("mr_busy", busy, 0);
        chk("mr_count", frame_count, 0);
        chk("mr_strobes", {frame_reset, adc_reset, convert, read, frame_done}, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("mr_idle", busy, 0);

        // 256 back-to-back frames wrap the frame counter to 0.
        expose_cycles = 6'd0;
        continuous = 1'b1;
        run_frames(1, 1, 256, 0);
        chk("wr_done", n_done, 256);
        chk("wr_gap", n_gap, 0);
        chk("wr_count", frame_count, 0);
        chk("wr_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Frame-level controller for the pixel sensor datapath. It steps each frame through erase, exposure, ADC reset, conversion and readout, and drives the control strobes of the pixel array, the exposure-duration counter, the ADC handler and the memory readout. It sits in the sensor top level between the external frame request and those blocks. It adds single-shot and continuous capture, multi-row readout sequencing, a frame counter and an ADC watchdog.

Parameters:
ROWS, 2, number of readout row groups sequenced per frame (>=1)
ERASE_CYCLES, 2, cycles frame_reset is held high (>=1)
READ_CYCLES, 1, cycles each readout row is held (>=1)
ADC_TIMEOUT, 255, maximum CONVERT cycles before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
start  in  1  frame request; level-sampled in IDLE and DONE
continuous  in  1  1 = chain frames back to back
expose_cycles  in  6  programmed exposure length; 0 = skip exposure
expose_finished  in  1  exposure-duration counter done
adc_finished  in  1  ADC ramp conversion done
frame_reset  out  1  pixel erase / exposure counter reset
expose_enable  out  1  enables the exposure-duration counter
adc_reset  out  1  ADC and pixel memory reset
convert  out  1  ADC conversion enable
read  out  1  memory readout active; pixel bus released by ADC
read_row  out  clog2(ROWS) (min 1)  row group being read
frame_done  out  1  one-cycle pulse at frame completion
busy  out  1  high in every state except IDLE
adc_timeout  out  1  sticky watchdog error flag
frame_count  out  8  completed frames, wraps 255 -> 0

Behaviour:
- All outputs are registered Moore decodes of the state. While reset=0, every output is 0 and the state is IDLE.
- States: IDLE, ERASE, EXPOSE, ADC_RST, CONVERT, READ, DONE. One shared cycle counter, cleared on every state entry.
- IDLE: if start=1 at a clock edge, go to ERASE, clear adc_timeout, and assert busy from the next cycle (1-cycle latency).
- ERASE: frame_reset=1 for exactly ERASE_CYCLES cycles. Then go to EXPOSE, or to ADC_RST if expose_cycles==0. expose_cycles is sampled on the last ERASE cycle.
- EXPOSE: expose_enable=1 until expose_finished=1 is sampled, then ADC_RST. The state is left on the same edge that expose_finished is seen.
- ADC_RST: adc_reset=1 for exactly 1 cycle, then CONVERT.
- CONVERT: convert=1 until adc_finished=1 is sampled, then READ.
- CONVERT watchdog: if ADC_TIMEOUT cycles pass in CONVERT without adc_finished, set adc_timeout=1 and go to IDLE. No frame_done pulse and no frame_count increment in that case.
- READ: read=1. read_row steps 0..ROWS-1, each value held READ_CYCLES cycles. After the last row go to DONE. read_row returns to 0 outside READ.
- DONE: 1 cycle. frame_done=1 and frame_count increments, wrapping modulo 256. Next state is ERASE if continuous=1 or start=1, otherwise IDLE.
- At most one of frame_reset, expose_enable, adc_reset, convert and read is high in any cycle.
- start while busy is ignored.
- Clearing continuous mid-frame lets the current frame finish, then go to IDLE.
- adc_finished arriving in the same cycle the timeout expires counts as success; no error is flagged.
- expose_finished or adc_finished outside their own states is ignored.
- Reset asserted mid-frame aborts immediately: state IDLE, all outputs 0, frame_count=0.

Optional Feature:
ADC_WATCHDOG_EN
- Defined: the CONVERT timeout described above is implemented and adc_timeout is live.
- Not defined: CONVERT waits on adc_finished indefinitely, adc_timeout is tied to 0, and the timeout comparator is absent.

Test Plan:
- Single frame. Defaults; start pulsed 1 cycle; expose_finished 5 cycles after expose_enable rises; adc_finished 10 cycles after convert rises. Required: frame_reset high 2 cycles; expose_enable 5; adc_reset 1; convert 10; read 2 with read_row 0 then 1; frame_done 1 cycle; frame_count=1; return to IDLE; busy low.
- Zero exposure. expose_cycles=0, start pulsed. Required: ERASE goes directly to ADC_RST, expose_enable never high, frame completes.
- Continuous. continuous=1 for 3 frames, then cleared during the 3rd frame's CONVERT. Required: frame_reset rises the cycle after each frame_done, exactly 3 frame_done pulses, frame_count=3, then IDLE.
- Watchdog. ADC_WATCHDOG_EN defined, ADC_TIMEOUT=8, adc_finished never asserted. Required: convert high 8 cycles, adc_timeout=1, IDLE, no frame_done. The next start clears adc_timeout. With the macro undefined, the block stays in CONVERT.
- Reset mid-frame and wrap. Drive reset=0 during EXPOSE: all outputs go to 0 asynchronously, before the next clk edge. Separately, run 256 frames: frame_count wraps to 0.
- Ignored events. start pulses during READ and adc_finished pulses during EXPOSE produce no state change. Check strobe mutual exclusion every cycle.
